// File: rtl/input_pkg.sv
// Shared types and constants for the keyboard/mouse/spinner input path feeding `system`.
// key_event_t is the queued keyboard word; mod_mask maps a scancode to its modifier bit.
package input_pkg;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } key_event_t;

  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL  = 2;
  localparam int MOD_RCTRL  = 3;
  localparam int MOD_LALT   = 4;
  localparam int MOD_RALT   = 5;
  localparam int MOD_LGUI   = 6;
  localparam int MOD_RGUI   = 7;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_LGUI   = 8'h1F;
  localparam logic [7:0] SC_RGUI   = 8'h27;

  // One-hot modifier mask for {extended, code}; zero for keys that are not modifiers.
  // E0 12 / E0 59 are the "fake shift" codes some keys emit and must not match.
  function automatic logic [7:0] mod_mask(input logic extended, input logic [7:0] code);
    logic [7:0] m;
    m = '0;
    case ({extended, code})
      {1'b0, SC_LSHIFT}: m[MOD_LSHIFT] = 1'b1;
      {1'b0, SC_RSHIFT}: m[MOD_RSHIFT] = 1'b1;
      {1'b0, SC_CTRL}:   m[MOD_LCTRL]  = 1'b1;
      {1'b1, SC_CTRL}:   m[MOD_RCTRL]  = 1'b1;
      {1'b0, SC_ALT}:    m[MOD_LALT]   = 1'b1;
      {1'b1, SC_ALT}:    m[MOD_RALT]   = 1'b1;
      {1'b1, SC_LGUI}:   m[MOD_LGUI]   = 1'b1;
      {1'b1, SC_RGUI}:   m[MOD_RGUI]   = 1'b1;
      default:           m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output and registered count/flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] dout_next;

  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign pop_ok     = rd_en && (count != '0);
  assign push_ok    = wr_en && ((count != CW'(DEPTH)) || pop_ok);

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_next = count - CW'(1);
  end

  // The head register looks one entry ahead: on a pop it takes the following
  // slot, or the incoming word when the queue held only the popped entry.
  always_comb begin
    dout_next = dout;
    if (pop_ok) begin
      if (count > CW'(1))
        dout_next = mem[rd_ptr_inc];
      else if (push_ok)
        dout_next = din;
    end else if (push_ok && (count == '0)) begin
      dout_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr_inc;
      count <= count_next;
      dout  <= dout_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/ps2_key_queue.sv
// Turns the toggle-encoded hps_io ps2_key word into a queue of key events,
// with a sticky drop flag and a live modifier-key byte.
module ps2_key_queue
  import input_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [10:0]   ps2_key,
  input  logic          rd,
  output logic [9:0]    key_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic [7:0]    mods
);

  logic       tog_q;
  logic       key_event;
  logic       drop;
  key_event_t ev;
  logic [7:0] ev_mask;

  // tog_q follows the toggle bit every cycle, reset included, so leaving reset
  // never sees a stale toggle; events are simply suppressed while in reset.
  always_ff @(posedge clk_sys)
    tog_q <= ps2_key[10];

  assign key_event = !reset && (ps2_key[10] != tog_q);
  assign ev        = key_event_t'(ps2_key[9:0]);
  assign ev_mask   = mod_mask(ev.extended, ev.code);
  assign drop      = key_event && full && !rd;

  sync_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .wr_en (key_event),
    .din   (ev),
    .rd_en (rd),
    .dout  (key_data),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

  // Modifiers track every event, dropped ones too, so mods never lags the keyboard.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      mods <= '0;
    else if (key_event) begin
      if (ev.pressed)
        mods <= mods | ev_mask;
      else
        mods <= mods & ~ev_mask;
    end
  end

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed bench for ps2_key_queue (DEPTH=8) with hand-computed expected values.
module tb_ps2_key_queue;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   ps2_key = '0;
  logic          rd = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [9:0]    key_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    mods;

  int checks = 0;
  int errors = 0;

  ps2_key_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .rd           (rd),
    .key_data     (key_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .mods         (mods)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic p, input logic e, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, e, c};
    tick();
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  logic [9:0] exp_q [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with toggle bit high, then hold input steady
    ps2_key = {1'b1, 10'h000};
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_mods", 32'(mods), 32'd0);
    check("rst_data", 32'(key_data), 32'd0);

    // single event then pop
    send(1'b1, 1'b0, 8'h1C);
    check("ev_empty", 32'(empty), 32'd0);
    check("ev_data", 32'(key_data), 32'h21C);
    check("ev_count", 32'(count), 32'd1);
    pop();
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_count", 32'(count), 32'd0);

    // RCtrl press / release
    send(1'b1, 1'b1, 8'h14);
    check("rctrl_mods", 32'(mods), 32'h08);
    check("rctrl_data", 32'(key_data), 32'h314);
    send(1'b0, 1'b1, 8'h14);
    check("rctrl_rel_mods", 32'(mods), 32'h00);
    check("rctrl_count", 32'(count), 32'd2);
    pop();
    check("rctrl_second", 32'(key_data), 32'h114);
    pop();
    check("rctrl_drained", 32'(empty), 32'd1);

    // modifier decode, including the E0 12 fake shift
    send(1'b1, 1'b0, 8'h12);
    check("lshift_mods", 32'(mods), 32'h01);
    send(1'b1, 1'b1, 8'h12);
    check("fake_shift_mods", 32'(mods), 32'h01);
    send(1'b1, 1'b1, 8'h1F);
    check("lgui_mods", 32'(mods), 32'h41);
    send(1'b0, 1'b0, 8'h12);
    check("lshift_rel_mods", 32'(mods), 32'h40);
    send(1'b0, 1'b1, 8'h1F);
    check("lgui_rel_mods", 32'(mods), 32'h00);
    check("mods_count", 32'(count), 32'd5);
    exp_q[0] = 10'h212; exp_q[1] = 10'h312; exp_q[2] = 10'h31F;
    exp_q[3] = 10'h012; exp_q[4] = 10'h11F;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mods_order%0d", i), 32'(key_data), 32'(exp_q[i]));
      pop();
    end
    check("mods_drained", 32'(empty), 32'd1);

    // fill, overflow, clear
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 8'(i + 1));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd0);
    send(1'b1, 1'b0, 8'h09);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd8);
    clr_overflow = 1'b1;
    send(1'b1, 1'b0, 8'h0A);
    clr_overflow = 1'b0;
    check("set_wins_ovf", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_order%0d", i), 32'(key_data), 32'h201 + 32'(i));
      pop();
    end
    check("fill_drained", 32'(empty), 32'd1);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 8'(8'h21 + i));
    rd = 1'b1;
    send(1'b1, 1'b0, 8'h30);
    rd = 1'b0;
    check("pp_count", 32'(count), 32'd8);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_full", 32'(full), 32'd1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("pp_order%0d", i), 32'(key_data), 32'h222 + 32'(i));
      pop();
    end
    check("pp_last", 32'(key_data), 32'h230);
    check("pp_last_count", 32'(count), 32'd1);
    pop();
    check("pp_drained", 32'(empty), 32'd1);

    // rd on empty is ignored, also with a same-cycle push
    pop();
    check("rd_empty_count", 32'(count), 32'd0);
    rd = 1'b1;
    send(1'b1, 1'b0, 8'h11);
    rd = 1'b0;
    check("rd_push_count", 32'(count), 32'd1);
    check("rd_push_data", 32'(key_data), 32'h211);
    check("lalt_mods", 32'(mods), 32'h10);
    send(1'b1, 1'b0, 8'h14);
    send(1'b1, 1'b0, 8'h1C);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_mods", 32'(mods), 32'h14);

    // asynchronous reset mid-operation
    reset = 1'b1;
    #2;
    check("arst_count", 32'(count), 32'd0);
    check("arst_mods", 32'(mods), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_data", 32'(key_data), 32'd0);
    ps2_key = {~ps2_key[10], 10'h21C};
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_queue.md
# ps2_key_queue

Event queue between the `hps_io` keyboard output and `system`. It converts the toggle-encoded `ps2_key` word into a FIFO of discrete key events that the CPU-side input logic pops one at a time. It also maintains a live modifier-key state byte. It runs on the core clock, alongside the joystick/spinner/mouse inputs feeding `system`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `CW`, `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk_sys` in 1: core clock, 24 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_key` in 11: from `hps_io`.
  - [10] toggles once per event.
  - [9] pressed(1)/released(0).
  - [8] E0-extended.
  - [7:0] scancode.
- `rd` in 1: pop strobe, one entry per cycle high.
- `key_data` out 10: head entry {pressed, extended, scancode}; valid when `empty`=0.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out CW: entries held.
- `overflow` out 1: sticky; an event was dropped.
- `clr_overflow` in 1: clears `overflow`.
- `mods` out 8: held modifiers.
  - [0] LShift 12, [1] RShift 59.
  - [2] LCtrl 14, [3] RCtrl E0 14.
  - [4] LAlt 11, [5] RAlt E0 11.
  - [6] LGui E0 1F, [7] RGui E0 27.

## Operation
- **Toggle tracking:** register `tog_q` holds the last seen `ps2_key[10]`.
  - During reset, `tog_q` continuously loads `ps2_key[10]`, so deasserting reset never creates a phantom event.
  - Event in cycle N ⇔ `ps2_key[10] != tog_q`. `tog_q` updates at the end of N.
- **Push:** on an event, {`ps2_key[9:0]`} is written at the tail when the FIFO is not full.
  - If full and `rd`=0: the event is dropped and `overflow`←1.
  - If full and `rd`=1: pop and push both occur; `count` is unchanged and `overflow` is not set.
- **Pop:** `rd`=1 with `empty`=0 advances the head.
  - `rd` while empty is ignored, including when a push happens in the same cycle. The pushed entry stays.
- **Overflow clear:** `clr_overflow` and an overflowing push in the same cycle leaves `overflow`=1 (set wins).
- **Modifier update:** `mods` updates on every detected event, including dropped ones.
  - A matching {extended, scancode} sets its bit on press and clears it on release.
  - Non-matching codes leave `mods` unchanged.
- **Pointers:** read and write pointers are log2(DEPTH) bits, wrap modulo DEPTH, and use a separate `count` for full/empty.
- **Reset values:**
  - `empty`=1, `full`=0, `count`=0.
  - `overflow`=0, `mods`=0.
  - `key_data`=0.
  - Pointers 0.
- Reset mid-operation discards all queued entries.

## Timing
- Event in cycle N → `empty`=0, `count`+1, `mods` updated, all visible in cycle N+1.
- `key_data` is registered and shows the head from N+1 when the FIFO was empty.
- Pop in cycle N → next head on `key_data` in N+1.
- `count` and flags are registered and reflect the post-edge state.
- Back-to-back events (toggle flips on consecutive cycles) are each captured.
- `hps_io` holds each word for ≥1 cycle, so no event is lost at the input.
- Throughput: 1 push and 1 pop per cycle.

## Structure
- Shared package `input_pkg`:
  - `key_event_t` packed struct {pressed, extended, code[7:0]}.
  - Modifier bit index localparams (`MOD_LSHIFT`..`MOD_RGUI`).
  - Scancode constants (`SC_LSHIFT`=8'h12, `SC_RSHIFT`=8'h59, `SC_CTRL`=8'h14, `SC_ALT`=8'h11, `SC_LGUI`=8'h1F, `SC_RGUI`=8'h27).
- One sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Registered-output, single clock, async reset.
  - Reusable for future mouse/spinner queues.
- The top holds toggle detection, overflow and modifier logic.

## Test plan
- Reset with `ps2_key[10]`=1, release reset, hold input for 10 cycles → `empty`=1, `count`=0.
- Toggle with {1,0,8'h1C} → next cycle `empty`=0, `key_data`=10'h21C. Then `rd`=1 → `empty`=1.
- Press E0 14, then release E0 14 → `mods`=8'h08 after the press, 8'h00 after the release. Both events are queued in order: 10'h314, 10'h114.
- DEPTH=8: 9 toggles with no `rd`:
  - After 8 toggles → `full`=1, `count`=8.
  - 9th event dropped → `overflow`=1; entries 1..8 pop intact.
  - `clr_overflow` → `overflow`=0.
- Full FIFO, event and `rd` in the same cycle → `count` stays 8, `overflow`=0, and the new entry appears last after 7 more pops.
- Empty FIFO, event and `rd` in the same cycle → `count`=1 next cycle. Assert `reset` with 3 entries queued → `count`=0 and `mods`=0 immediately, asynchronously.
